mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 31 +++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state encoding, timeout default and alignment helper for the MEM stage
package mem_access_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mauState_t;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic isAligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts WAIT cycles and flags the last permitted cycle before timeout
module mem_wait_timer
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage: branch resolve, word-aligned load/store handshake, writeback register
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inAdder,
    input  logic        inZf,
    input  logic [31:0] inOutAlu,
    input  logic [31:0] inRD2,
    input  logic [4:0]  inMux5b,
    input  logic        inBranch,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        outPcSrc,
    output logic [31:0] outBranchTarget,
    output logic        outStall,
    output logic [31:0] outWbData,
    output logic [4:0]  outWbReg,
    output logic        outRegWrite,
    output logic        outValid,
    output logic        outMisalign,
    output logic        outBusErr
);

    mauState_t state, nextState;

    logic       isMemOp;
    logic       aligned;
    logic       issue;
    logic       misalignOp;
    logic       ackDone;
    logic       timeoutDone;
    logic       timeout;
    logic [4:0] latReg;
    logic       latRegWrite;
    logic       latMemToReg;

    assign outPcSrc        = inBranch & inZf;
    assign outBranchTarget = inAdder;

    assign isMemOp = inMemRead | inMemWrite;
    assign aligned = isAligned(inOutAlu);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) uTimer (
        .clk     (clk),
        .rst     (rst),
        .clear   (issue),
        .enable  (state == WAIT),
        .expired (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (isMemOp && aligned) nextState = WAIT;
            WAIT:    if (memAck || timeout) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Stall also drops on the timeout cycle so upstream retires the failed op instead of reissuing it.
    always_comb begin
        issue       = 1'b0;
        misalignOp  = 1'b0;
        ackDone     = 1'b0;
        timeoutDone = 1'b0;
        outStall    = 1'b0;
        case (state)
            IDLE: begin
                issue      = isMemOp && aligned;
                misalignOp = isMemOp && !aligned;
                outStall   = isMemOp && aligned;
            end
            WAIT: begin
                ackDone     = memAck;
                timeoutDone = !memAck && timeout;
                outStall    = !(memAck || timeout);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            outWbData   <= '0;
            outWbReg    <= '0;
            outRegWrite <= 1'b0;
            outValid    <= 1'b0;
            outMisalign <= 1'b0;
            outBusErr   <= 1'b0;
            latReg      <= '0;
            latRegWrite <= 1'b0;
            latMemToReg <= 1'b0;
        end else begin
            outValid    <= 1'b0;
            outMisalign <= 1'b0;
            outBusErr   <= 1'b0;
            outRegWrite <= 1'b0;
            if (issue) begin
                memReq      <= 1'b1;
                memWe       <= inMemWrite;
                memAddr     <= inOutAlu;
                memWdata    <= inRD2;
                latReg      <= inMux5b;
                latRegWrite <= inRegWrite;
                latMemToReg <= inMemToReg;
            end else if (misalignOp) begin
                outValid    <= 1'b1;
                outMisalign <= 1'b1;
                outWbData   <= inOutAlu;
                outWbReg    <= inMux5b;
            end else if (state == IDLE) begin
                outValid    <= 1'b1;
                outWbData   <= inOutAlu;
                outWbReg    <= inMux5b;
                outRegWrite <= inRegWrite;
            end else if (ackDone) begin
                memReq      <= 1'b0;
                memWe       <= 1'b0;
                outValid    <= 1'b1;
                outWbReg    <= latReg;
                outRegWrite <= memWe ? 1'b0 : latRegWrite;
                outWbData   <= (!memWe && latMemToReg) ? memRdata : memAddr;
            end else if (timeoutDone) begin
                memReq    <= 1'b0;
                memWe     <= 1'b0;
                outValid  <= 1'b1;
                outBusErr <= 1'b1;
                outWbReg  <= latReg;
                outWbData <= memAddr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inAdder, inOutAlu, inRD2, memRdata;
    logic [4:0]  inMux5b;
    logic        inZf, inBranch, inMemRead, inMemWrite, inRegWrite, inMemToReg, memAck;
    logic        memReq, memWe, outPcSrc, outStall, outRegWrite, outValid, outMisalign, outBusErr;
    logic [31:0] memAddr, memWdata, outBranchTarget, outWbData;
    logic [4:0]  outWbReg;

    int checks = 0;
    int errors = 0;
    int reqCycles;

    typedef struct {
        logic [31:0] wbData;
        logic [4:0]  wbReg;
        logic        regWrite;
        logic        misalign;
        logic        busErr;
        logic        chkWb;
    } exp_t;

    exp_t sbq[$];
    exp_t monE;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .inAdder         (inAdder),
        .inZf            (inZf),
        .inOutAlu        (inOutAlu),
        .inRD2           (inRD2),
        .inMux5b         (inMux5b),
        .inBranch        (inBranch),
        .inMemRead       (inMemRead),
        .inMemWrite      (inMemWrite),
        .inRegWrite      (inRegWrite),
        .inMemToReg      (inMemToReg),
        .memReq          (memReq),
        .memWe           (memWe),
        .memAddr         (memAddr),
        .memWdata        (memWdata),
        .memRdata        (memRdata),
        .memAck          (memAck),
        .outPcSrc        (outPcSrc),
        .outBranchTarget (outBranchTarget),
        .outStall        (outStall),
        .outWbData       (outWbData),
        .outWbReg        (outWbReg),
        .outRegWrite     (outRegWrite),
        .outValid        (outValid),
        .outMisalign     (outMisalign),
        .outBusErr       (outBusErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setBubble();
        inAdder    = '0;
        inZf       = 1'b0;
        inOutAlu   = '0;
        inRD2      = '0;
        inMux5b    = '0;
        inBranch   = 1'b0;
        inMemRead  = 1'b0;
        inMemWrite = 1'b0;
        inRegWrite = 1'b0;
        inMemToReg = 1'b0;
    endtask

    task automatic pushExp(input logic [31:0] d, input logic [4:0] r, input logic rw,
                           input logic mis, input logic be, input logic chk);
        exp_t e;
        e.wbData   = d;
        e.wbReg    = r;
        e.regWrite = rw;
        e.misalign = mis;
        e.busErr   = be;
        e.chkWb    = chk;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            setBubble();
            pushExp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && outValid) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=%0d expected=%0d", 1, 0);
            end
            if (sbq.size() != 0) begin
                monE = sbq.pop_front();
                check("wb_flags", {29'd0, outRegWrite, outMisalign, outBusErr},
                      {29'd0, monE.regWrite, monE.misalign, monE.busErr});
                if (monE.chkWb) begin
                    check("wb_data", outWbData, monE.wbData);
                    check("wb_reg", {27'd0, outWbReg}, {27'd0, monE.wbReg});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        memAck   = 1'b0;
        memRdata = '0;
        setBubble();
        @(negedge clk);
        check("rst_memReq", {31'd0, memReq}, 32'd0);
        check("rst_memWe", {31'd0, memWe}, 32'd0);
        check("rst_outValid", {31'd0, outValid}, 32'd0);
        check("rst_outRegWrite", {31'd0, outRegWrite}, 32'd0);
        check("rst_outWbData", outWbData, 32'd0);
        check("rst_outWbReg", {27'd0, outWbReg}, 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        rst = 1'b0;
        idle(2);

        // Plain ALU result plus branch decision
        inOutAlu   = 32'h0000_0010;
        inMux5b    = 5'd5;
        inRegWrite = 1'b1;
        inAdder    = 32'h0000_1000;
        inBranch   = 1'b1;
        inZf       = 1'b1;
        pushExp(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("alu_stall", {31'd0, outStall}, 32'd0);
        check("br_pcsrc_taken", {31'd0, outPcSrc}, 32'd1);
        check("br_target", outBranchTarget, 32'h0000_1000);
        inZf = 1'b0;
        #1;
        check("br_pcsrc_not_taken", {31'd0, outPcSrc}, 32'd0);
        @(negedge clk);
        idle(1);

        // Load 0x40, ack in the third WAIT cycle
        setBubble();
        inMemRead  = 1'b1;
        inMemToReg = 1'b1;
        inRegWrite = 1'b1;
        inOutAlu   = 32'h40;
        inMux5b    = 5'd7;
        pushExp(32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("ld_stall_idle", {31'd0, outStall}, 32'd1);
        reqCycles = 0;
        @(negedge clk);
        check("ld_addr", memAddr, 32'h40);
        check("ld_we", {31'd0, memWe}, 32'd0);
        check("ld_stall_wait", {31'd0, outStall}, 32'd1);
        if (memReq) reqCycles++;
        @(negedge clk);
        if (memReq) reqCycles++;
        @(negedge clk);
        if (memReq) reqCycles++;
        memAck   = 1'b1;
        memRdata = 32'hDEADBEEF;
        #1;
        check("ld_stall_ack", {31'd0, outStall}, 32'd0);
        @(negedge clk);
        memAck = 1'b0;
        check("ld_req_drop", {31'd0, memReq}, 32'd0);
        check("ld_req_cycles", reqCycles, 32'd3);
        idle(2);

        // Store 0x44
        setBubble();
        inMemWrite = 1'b1;
        inOutAlu   = 32'h44;
        inRD2      = 32'h12345678;
        inMux5b    = 5'd9;
        inRegWrite = 1'b1;
        pushExp(32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("st_req", {31'd0, memReq}, 32'd1);
        check("st_we", {31'd0, memWe}, 32'd1);
        check("st_wdata", memWdata, 32'h12345678);
        @(negedge clk);
        check("st_wdata_held", memWdata, 32'h12345678);
        check("st_addr_held", memAddr, 32'h44);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        check("st_req_drop", {31'd0, memReq}, 32'd0);
        idle(1);

        // Read and write both asserted behave as a store
        setBubble();
        inMemRead  = 1'b1;
        inMemWrite = 1'b1;
        inMemToReg = 1'b1;
        inRegWrite = 1'b1;
        inOutAlu   = 32'h48;
        inRD2      = 32'hA5A5_5A5A;
        inMux5b    = 5'd2;
        pushExp(32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rw_we", {31'd0, memWe}, 32'd1);
        check("rw_wdata", memWdata, 32'hA5A5_5A5A);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        idle(1);

        // Misaligned load 0x42
        setBubble();
        inMemRead  = 1'b1;
        inMemToReg = 1'b1;
        inRegWrite = 1'b1;
        inOutAlu   = 32'h42;
        inMux5b    = 5'd3;
        pushExp(32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("mis_stall", {31'd0, outStall}, 32'd0);
        @(negedge clk);
        check("mis_noreq", {31'd0, memReq}, 32'd0);
        idle(1);

        // Load 0x80 that is never acknowledged
        setBubble();
        inMemRead  = 1'b1;
        inMemToReg = 1'b1;
        inRegWrite = 1'b1;
        inOutAlu   = 32'h80;
        inMux5b    = 5'd4;
        pushExp(32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        reqCycles = 0;
        @(negedge clk);
        while (memReq && reqCycles < 40) begin
            reqCycles++;
            @(negedge clk);
        end
        check("to_req_cycles", reqCycles, 32'd16);
        setBubble();
        pushExp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("to_idle_stall", {31'd0, outStall}, 32'd0);
        @(negedge clk);
        idle(1);

        // Reset during WAIT, then a late ack
        setBubble();
        inMemRead  = 1'b1;
        inMemToReg = 1'b1;
        inRegWrite = 1'b1;
        inOutAlu   = 32'h40;
        inMux5b    = 5'd6;
        @(negedge clk);
        check("rw_wait_req", {31'd0, memReq}, 32'd1);
        rst = 1'b1;
        setBubble();
        inBranch = 1'b1;
        inZf     = 1'b1;
        #1;
        check("rst_wait_req", {31'd0, memReq}, 32'd0);
        check("rst_wait_valid", {31'd0, outValid}, 32'd0);
        check("rst_wait_stall", {31'd0, outStall}, 32'd0);
        check("rst_pcsrc", {31'd0, outPcSrc}, 32'd1);
        @(negedge clk);
        rst      = 1'b0;
        memAck   = 1'b1;
        memRdata = 32'hBADC0DE0;
        pushExp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("late_ack_stall", {31'd0, outStall}, 32'd0);
        @(negedge clk);
        memAck = 1'b0;
        check("late_ack_req", {31'd0, memReq}, 32'd0);
        idle(2);

        #2;
        check("sb_drain", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
